uart_tx_buffered: RTL
=====================

# uart_tx_buffered

Buffered UART transmitter, 8N1, LSB first: the return path from the FPGA to the host over the same serial link the bootloader receives on. Accepts bytes on a valid/ready stream from the bootloader command logic (e.g. SPI read-back data), queues them in a small FIFO, and serialises them back-to-back on `uart_tx`. Line format and bit timing match the bootloader's receive side: 12 MHz clock, 9600 baud.

## Interface
- `CLK_FREQ`, 12000000: clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `FIFO_DEPTH`, 16: byte entries, power of two, minimum 2.
- `clk`  input  1  system clock; single clock domain.
- `rst`  input  1  asynchronous, active-high reset.
- `tx_data`  input  8  byte to send.
- `tx_valid`  input  1  `tx_data` is valid.
- `tx_ready`  output  1  FIFO can accept a byte.
- `uart_tx`  output  1  serial line, idle high.
- `busy`  output  1  FIFO non-empty or a frame in progress.

## Operation
- `DIV = CLK_FREQ / BAUD`, integer division; 1250 at defaults. Every bit lasts exactly DIV cycles.
- Push: byte written on a rising edge with `tx_valid && tx_ready`. `tx_ready = (count != FIFO_DEPTH)`, combinational from the registered count. No push while full; `tx_data` is not sampled when `tx_ready` is low.
- Serialiser FSM states:
  - IDLE: `uart_tx=1`. If the FIFO is non-empty, pop the head into the shift register, load the bit counter with DIV-1, and go to START.
  - START: `uart_tx=0` for DIV cycles, then go to DATA with bit index 0.
  - DATA: `uart_tx=shift[0]`. Each DIV cycles, shift right and increment the index. After bit 7, go to STOP.
  - STOP: `uart_tx=1` for DIV cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START, giving no idle gap. Otherwise go to IDLE.
- `uart_tx` is a registered output; it is never driven combinationally from the FSM.
- A push and a pop in the same cycle leave the count unchanged. This is legal when the FIFO is neither empty nor full. When full, push is blocked. When empty, no pop occurs.
- `busy = (count != 0) || (state != IDLE)`, registered or combinational from registers.
- Pointers wrap modulo FIFO_DEPTH. The count is held in log2(FIFO_DEPTH)+1 bits so it can represent full.

## Timing
- Reset values: `uart_tx=1`, `tx_ready=1`, `busy=0`, FSM in IDLE, FIFO empty, counters at 0.
- Reset asserted mid-frame aborts the frame: `uart_tx` goes high asynchronously and queued bytes are discarded. The receiver sees a truncated or framing-error byte; this is accepted behaviour.
- Latency with the FIFO empty and FSM in IDLE:
  - Byte pushed at edge N; count becomes non-zero after N.
  - Pop and START entry at edge N+1; `uart_tx` falls after edge N+1.
  - Frame occupies 10·DIV cycles: start, D0..D7, stop.
- Back-to-back: consecutive queued bytes produce start-bit falling edges exactly 10·DIV cycles apart.
- `busy` deasserts on the first cycle in IDLE with an empty FIFO, i.e. one cycle after the stop bit's last cycle.
- Throughput is bounded by the line rate, one byte per 10·DIV cycles. The FIFO absorbs bursts up to FIFO_DEPTH bytes plus the one in the shifter.

## Structure
- Shared include `uart_defs.vh`:
  - FSM state encodings (IDLE/START/DATA/STOP).
  - Default `CLK_FREQ`/`BAUD` and the `DIV` derivation, so the bootloader receive side and this block use one definition.
- Sub-module `sync_fifo`, parameterised on width (8) and depth:
  - Ports: push/pop, data in/out, `full`, `empty`, `count`.
  - Show-ahead output: head valid whenever not empty.
- Top module: FSM, bit counter (width clog2(DIV)), 3-bit index, and shift register.

## Test plan
- Reset then idle 10·DIV cycles: `uart_tx` stays 1, `busy=0`, `tx_ready=1`.
- Push 0x9F: `uart_tx` falls exactly one cycle after the push edge. Sampling at bit centres (DIV/2 + k·DIV) yields 0,1,1,1,1,1,0,0,1,1. `busy` clears 10·DIV+1 cycles after the pop.
- Push 0x01, 0x02, 0x00, 0x05, 0x00 on consecutive cycles: the bench UART monitor decodes the same five bytes in order. Start edges are 10·DIV apart with no extra idle cycles.
- Push 17 bytes (0x00..0x10) with `tx_valid` held high:
  - `tx_ready` drops once 16 are queued plus 1 in flight.
  - `tx_ready` rises within one cycle of the next pop.
  - All 17 bytes are decoded in order, with no loss or duplication.
- Push 0xA5 and 0x3C, then assert `rst` during the DATA state of the first byte:
  - `uart_tx=1` immediately and `busy=0`.
  - After release, push 0x55: only 0x55 is transmitted, with correct framing.
- Parameter sweep with `CLK_FREQ=1000000`, `BAUD=115200` (DIV=8): push 0xFF then 0x00 and check each bit lasts exactly 8 cycles.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// ============================================================================
// uart_tx_buffered_pkg
// ----------------------------------------------------------------------------
// Definitions shared by the buffered UART transmitter and the bootloader
// receive side, so both ends derive their bit timing from one place.
//   DEFAULT_CLK_FREQ : system clock in Hz
//   DEFAULT_BAUD     : serial line rate in bit/s
//   tx_state_t       : serialiser FSM state encoding
//   baud_div()       : clock cycles per serial bit (integer division)
// ============================================================================
package uart_tx_buffered_pkg;

    localparam int DEFAULT_CLK_FREQ = 12_000_000;
    localparam int DEFAULT_BAUD     = 9_600;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Truncating division; the small rate error this introduces is the same
    // on both ends of the link because both use this function.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// ============================================================================
// sync_fifo
// ----------------------------------------------------------------------------
// Single-clock show-ahead FIFO: dout presents the head entry whenever the
// FIFO is not empty, so a pop consumes the value already visible.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write din (ignored while full)
//   pop      : discard head entry (ignored while empty)
//   din      : write data
//   dout     : head entry, valid while !empty
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : number of stored entries, one extra bit to represent full
// ============================================================================
module sync_fifo
    import uart_tx_buffered_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// ============================================================================
// uart_tx_buffered
// ----------------------------------------------------------------------------
// Buffered 8N1 UART transmitter, LSB first. Bytes arrive on a valid/ready
// stream, wait in a FIFO and are serialised back-to-back with no idle gap
// between frames while the FIFO has data.
//   clk      : system clock
//   rst      : asynchronous active-high reset (aborts any frame in progress)
//   tx_data  : byte to send
//   tx_valid : tx_data is valid
//   tx_ready : FIFO can accept a byte
//   uart_tx  : serial line, idle high, registered
//   busy     : FIFO non-empty or a frame in progress
// ============================================================================
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       busy
);

    localparam int DIV    = baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DIV_M1 = DIV - 1;
    localparam logic [CNT_W-1:0] BIT_LAST = DIV_M1[CNT_W-1:0];
    localparam int AW     = $clog2(FIFO_DEPTH);

    tx_state_t        state;
    tx_state_t        state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             uart_tx_next;
    logic             bit_done;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic [AW:0]      fifo_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .pop   (fifo_pop),
        .din   (tx_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign busy     = (fifo_count != '0) || (state != ST_IDLE);

    // Next-state logic. The bit counter runs down from DIV-1 in every
    // non-idle state and reloads when it reaches zero, so each bit lasts
    // exactly DIV cycles. The line level is computed from the *next* state
    // so the registered uart_tx changes on the same edge as the state.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        fifo_pop     = 1'b0;
        uart_tx_next = 1'b1;
        bit_done     = (bit_cnt == '0);

        if (state != ST_IDLE) begin
            bit_cnt_next = bit_done ? BIT_LAST : bit_cnt - 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shift_next   = fifo_head;
                    bit_cnt_next = BIT_LAST;
                    state_next   = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    bit_idx_next = 3'd0;
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        shift_next   = {1'b0, shift[7:1]};
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                // Chaining straight into the next start bit keeps queued
                // bytes back-to-back on the line.
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_head;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        case (state_next)
            ST_START: uart_tx_next = 1'b0;
            ST_DATA:  uart_tx_next = shift_next[0];
            default:  uart_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            uart_tx <= uart_tx_next;
        end
    end

endmodule
